alu_issue_stage: RTL and testbench

Two-stage pipelined front end for the 32-bit ALU in the EX stage. It accepts operation requests (main-decoder ALU class, funct field, two operands) over a valid/ready handshake and decodes them into the ALU's 3-bit mode code. It drives the existing combinational ALU and returns a registered result, zero flag and illegal-op flag over a second valid/ready handshake. It sustains one operation per cycle and stalls cleanly under downstream backpressure.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_issue_stage_if.sv | 29 ++
 rtl/alu_issue_stage_alu.sv | 33 +++
 rtl/alu_issue_stage_decode.sv | 42 ++++
 rtl/alu_issue_stage.sv | 107 ++++++++++
 tb/tb_alu_issue_stage.sv | 207 ++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU mode codes, main-decoder
// ALU class codes and the R-type funct encodings the decoder recognises.
package alu_pkg;

    localparam int DATA_W = 32;

    typedef logic [2:0] alu_mode_t;

    localparam alu_mode_t ALU_OR   = 3'b000;
    localparam alu_mode_t ALU_AND  = 3'b001;
    localparam alu_mode_t ALU_XOR  = 3'b010;
    localparam alu_mode_t ALU_ADD  = 3'b011;
    localparam alu_mode_t ALU_NOR  = 3'b100;
    localparam alu_mode_t ALU_NAND = 3'b101;
    localparam alu_mode_t ALU_SLT  = 3'b110;
    localparam alu_mode_t ALU_SUB  = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RAW   = 2'b11;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_XOR = 6'b100110;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Request/response bundle of the ALU issue stage.
//   request : in_valid, in_ready, alu_op, funct, a, b
//   response: out_valid, out_ready, result, zero, illegal
//   status  : illegal_cnt (saturating count of accepted illegal requests)
// master = requester/consumer side, slave = the issue stage.
interface alu_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic [15:0] illegal_cnt;

    modport master (
        output in_valid, alu_op, funct, a, b, out_ready,
        input  in_ready, out_valid, result, zero, illegal, illegal_cnt
    );

    modport slave (
        input  in_valid, alu_op, funct, a, b, out_ready,
        output in_ready, out_valid, result, zero, illegal, illegal_cnt
    );
endinterface

// File: rtl/alu_issue_stage_alu.sv
// alu32: the existing combinational 32-bit ALU.
//   i_mode   : 3-bit mode code
//   i_a, i_b : operands
//   o_result : ALU output
module alu32
    import alu_pkg::*;
(
    input  alu_mode_t   i_mode,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);

    logic [31:0] w_diff;

    assign w_diff = i_a - i_b;

    always_comb begin
        o_result = 32'd0;
        case (i_mode)
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_ADD:  o_result = i_a + i_b;
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_NAND: o_result = ~(i_a & i_b);
            // Sign of the wrapped difference, as the original ALU does.
            ALU_SLT:  o_result = {31'd0, w_diff[31]};
            default:  o_result = w_diff;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage_decode.sv
// alu_mode_decode: combinational translation of (alu_op, funct) into the
// ALU 3-bit mode code.
//   i_alu_op  : main-decoder ALU class
//   i_funct   : instruction funct field
//   o_mode    : ALU mode code
//   o_illegal : R-type funct not recognised (mode falls back to ADD)
module alu_mode_decode
    import alu_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [5:0] i_funct,
    output alu_mode_t  o_mode,
    output logic       o_illegal
);

    always_comb begin
        o_mode    = ALU_ADD;
        o_illegal = 1'b0;
        case (i_alu_op)
            ALUOP_ADD: o_mode = ALU_ADD;
            ALUOP_SUB: o_mode = ALU_SUB;
            ALUOP_RAW: o_mode = i_funct[2:0];
            default: begin
                case (i_funct)
                    FUNCT_ADD: o_mode = ALU_ADD;
                    FUNCT_SUB: o_mode = ALU_SUB;
                    FUNCT_AND: o_mode = ALU_AND;
                    FUNCT_OR:  o_mode = ALU_OR;
                    FUNCT_XOR: o_mode = ALU_XOR;
                    FUNCT_NOR: o_mode = ALU_NOR;
                    FUNCT_SLT: o_mode = ALU_SLT;
                    default: begin
                        // Unknown op still executes as ADD so the pipe never bubbles.
                        o_mode    = ALU_ADD;
                        o_illegal = 1'b1;
                    end
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage pipelined front end for the 32-bit ALU.
// Stage 1 registers the decoded mode, operands and illegal flag; stage 2
// registers the ALU result, zero flag and illegal flag.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, flushes both stages
//   bus   : request/response handshakes and illegal_cnt (slave side)
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_stage_if.slave   bus
);

    alu_mode_t   w_dec_mode;
    logic        w_dec_illegal;
    logic [31:0] w_alu_result;

    logic        w_s2_adv;
    logic        w_s1_adv;
    logic        w_in_ready;
    logic        w_accept;

    logic        r_s1_valid;
    alu_mode_t   r_s1_mode;
    logic [31:0] r_s1_a;
    logic [31:0] r_s1_b;
    logic        r_s1_illegal;

    logic        r_s2_valid;
    logic [31:0] r_result;
    logic        r_zero;
    logic        r_illegal;

    logic [15:0] r_illegal_cnt;

    alu_mode_decode u_decode (
        .i_alu_op  (bus.alu_op),
        .i_funct   (bus.funct),
        .o_mode    (w_dec_mode),
        .o_illegal (w_dec_illegal)
    );

    alu32 u_alu (
        .i_mode   (r_s1_mode),
        .i_a      (r_s1_a),
        .i_b      (r_s1_b),
        .o_result (w_alu_result)
    );

    // in_ready depends on out_ready and register state only, never on in_valid.
    assign w_s2_adv   = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = r_s1_valid && w_s2_adv;
    assign w_in_ready = !r_s1_valid || w_s2_adv;
    assign w_accept   = bus.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_mode    <= ALU_ADD;
            r_s1_a       <= 32'd0;
            r_s1_b       <= 32'd0;
            r_s1_illegal <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid   <= 1'b1;
            r_s1_mode    <= w_dec_mode;
            r_s1_a       <= bus.a;
            r_s1_b       <= bus.b;
            r_s1_illegal <= w_dec_illegal;
        end else if (w_s1_adv) begin
            r_s1_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= 32'd0;
            r_zero     <= 1'b0;
            r_illegal  <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            // Data only moves with a real op so a drained stage keeps its last value.
            if (r_s1_valid) begin
                r_result  <= w_alu_result;
                r_zero    <= (w_alu_result == 32'd0);
                r_illegal <= r_s1_illegal;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal_cnt <= 16'd0;
        end else if (w_accept && w_dec_illegal && (r_illegal_cnt != 16'hFFFF)) begin
            r_illegal_cnt <= r_illegal_cnt + 16'd1;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_s2_valid;
    assign bus.result      = r_result;
    assign bus.zero        = r_zero;
    assign bus.illegal     = r_illegal;
    assign bus.illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    alu_issue_stage_if bus_if ();

    alu_issue_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [5:0] f,
                         input logic [31:0] va, input logic [31:0] vb);
        bus_if.in_valid = 1'b1;
        bus_if.alu_op   = op;
        bus_if.funct    = f;
        bus_if.a        = va;
        bus_if.b        = vb;
    endtask

    task automatic send(input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] va, input logic [31:0] vb);
        drive(op, f, va, vb);
        tick();
    endtask

    task automatic idle();
        bus_if.in_valid = 1'b0;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.alu_op    = 2'b00;
        bus_if.funct     = 6'd0;
        bus_if.a         = 32'd0;
        bus_if.b         = 32'd0;
        bus_if.out_ready = 1'b1;
        #22;
        chk("rst_out_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("rst_result", bus_if.result, 32'd0);
        chk("rst_zero", {31'd0, bus_if.zero}, 32'd0);
        chk("rst_illegal", {31'd0, bus_if.illegal}, 32'd0);
        chk("rst_illegal_cnt", {16'd0, bus_if.illegal_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // ADD 5+7
        send(ALUOP_ADD, 6'd0, 32'd5, 32'd7);
        idle();
        chk("add_lat1_valid", {31'd0, bus_if.out_valid}, 32'd0);
        tick();
        chk("add_valid", {31'd0, bus_if.out_valid}, 32'd1);
        chk("add_result", bus_if.result, 32'd12);
        chk("add_zero", {31'd0, bus_if.zero}, 32'd0);
        chk("add_illegal", {31'd0, bus_if.illegal}, 32'd0);
        tick();
        chk("add_drained", {31'd0, bus_if.out_valid}, 32'd0);

        // SUB equal operands -> zero
        send(ALUOP_SUB, 6'd0, 32'h1234, 32'h1234);
        idle();
        tick();
        chk("sub_result", bus_if.result, 32'd0);
        chk("sub_zero", {31'd0, bus_if.zero}, 32'd1);

        // R-type SLT -1 < 1
        send(ALUOP_RTYPE, FUNCT_SLT, 32'hFFFF_FFFF, 32'd1);
        idle();
        tick();
        chk("slt_result", bus_if.result, 32'd1);
        chk("slt_zero", {31'd0, bus_if.zero}, 32'd0);

        // R-type SUB and raw-mode NAND
        send(ALUOP_RTYPE, FUNCT_SUB, 32'd10, 32'd3);
        idle();
        tick();
        chk("rsub_result", bus_if.result, 32'd7);
        send(ALUOP_RAW, 6'b000101, 32'hF0F0_F0F0, 32'hFF00_FF00);
        idle();
        tick();
        chk("raw_nand_result", bus_if.result, 32'h0FFF_0FFF);

        // Back-to-back logic ops at full throughput
        send(ALUOP_RTYPE, FUNCT_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
        send(ALUOP_RTYPE, FUNCT_OR,  32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("b2b_and_valid", {31'd0, bus_if.out_valid}, 32'd1);
        chk("b2b_and", bus_if.result, 32'hF000_F000);
        chk("b2b_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        send(ALUOP_RTYPE, FUNCT_XOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("b2b_or", bus_if.result, 32'hFFF0_FFF0);
        send(ALUOP_RTYPE, FUNCT_NOR, 32'hF0F0_F0F0, 32'hFF00_FF00);
        chk("b2b_xor", bus_if.result, 32'h0FF0_0FF0);
        idle();
        tick();
        chk("b2b_nor", bus_if.result, 32'h000F_000F);
        chk("b2b_nor_valid", {31'd0, bus_if.out_valid}, 32'd1);
        tick();
        chk("b2b_drained", {31'd0, bus_if.out_valid}, 32'd0);

        // Backpressure: out_ready low for 4 edges, 3 requests offered
        bus_if.out_ready = 1'b0;
        drive(ALUOP_ADD, 6'd0, 32'd1, 32'd1);
        chk("bp_ready_empty", {31'd0, bus_if.in_ready}, 32'd1);
        tick();
        drive(ALUOP_ADD, 6'd0, 32'd2, 32'd2);
        chk("bp_ready_one", {31'd0, bus_if.in_ready}, 32'd1);
        tick();
        drive(ALUOP_ADD, 6'd0, 32'd3, 32'd3);
        chk("bp_ready_full", {31'd0, bus_if.in_ready}, 32'd0);
        chk("bp_valid", {31'd0, bus_if.out_valid}, 32'd1);
        chk("bp_result_a", bus_if.result, 32'd2);
        tick();
        chk("bp_hold1_result", bus_if.result, 32'd2);
        chk("bp_hold1_ready", {31'd0, bus_if.in_ready}, 32'd0);
        tick();
        chk("bp_hold2_result", bus_if.result, 32'd2);
        chk("bp_hold2_valid", {31'd0, bus_if.out_valid}, 32'd1);
        bus_if.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, bus_if.in_ready}, 32'd1);
        tick();
        idle();
        chk("bp_result_b", bus_if.result, 32'd4);
        tick();
        chk("bp_result_c", bus_if.result, 32'd6);
        chk("bp_result_c_valid", {31'd0, bus_if.out_valid}, 32'd1);
        tick();
        chk("bp_drained", {31'd0, bus_if.out_valid}, 32'd0);

        // Illegal R-type funct still executes as ADD
        send(ALUOP_RTYPE, 6'b000000, 32'd1, 32'd2);
        idle();
        chk("ill_cnt_1", {16'd0, bus_if.illegal_cnt}, 32'd1);
        tick();
        chk("ill_result", bus_if.result, 32'd3);
        chk("ill_flag", {31'd0, bus_if.illegal}, 32'd1);
        for (int i = 0; i < 65534; i++) begin
            send(ALUOP_RTYPE, 6'b111111, 32'd0, 32'd0);
        end
        idle();
        tick();
        chk("ill_cnt_max", {16'd0, bus_if.illegal_cnt}, 32'h0000_FFFF);
        send(ALUOP_RTYPE, 6'b000001, 32'd0, 32'd0);
        idle();
        chk("ill_cnt_sat", {16'd0, bus_if.illegal_cnt}, 32'h0000_FFFF);
        send(ALUOP_ADD, 6'd0, 32'd4, 32'd4);
        idle();
        tick();
        chk("legal_after_sat", {31'd0, bus_if.illegal}, 32'd0);
        chk("legal_after_sat_cnt", {16'd0, bus_if.illegal_cnt}, 32'h0000_FFFF);
        tick();

        // Reset with both stages full
        bus_if.out_ready = 1'b0;
        send(ALUOP_ADD, 6'd0, 32'd9, 32'd9);
        send(ALUOP_ADD, 6'd0, 32'd8, 32'd8);
        idle();
        chk("prerst_valid", {31'd0, bus_if.out_valid}, 32'd1);
        chk("prerst_ready", {31'd0, bus_if.in_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        chk("midrst_result", bus_if.result, 32'd0);
        chk("midrst_cnt", {16'd0, bus_if.illegal_cnt}, 32'd0);
        chk("midrst_ready", {31'd0, bus_if.in_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("postrst_valid", {31'd0, bus_if.out_valid}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
